// File: rtl/complex_mult_sched.sv
// ---------------------------------------------------------------------------
// complex_mult_sched
//
// Round-robin front end for one shared complex multiplier. Up to C_NCH
// requesters each offer an operand pair over valid/ready. At most one pair
// per cycle is issued to the multiplier, tagged with its channel. Results
// come back with that tag, and any valid/tag misalignment is flagged.
//
// Ports
//   I_clk, I_rst_n                    clock, async active-low reset
//   I_ch_en[C_NCH]                    per-channel enable
//   I_req_v[C_NCH]                    per-channel request valid
//   O_req_ready[C_NCH]                one-hot-or-zero grant (combinational)
//   I_req_d1i/d1q/d2i/d2q             flattened per-channel operands
//   O_mult_d1i/d1q/d2i/d2q, O_mult_v  registered operands to the multiplier
//   I_mult_i/q, I_mult_v              multiplier result
//   O_dout_i/q, O_dout_ch, O_dout_v   registered, tagged result
//   O_err                             sticky tag-alignment error
// ---------------------------------------------------------------------------
module complex_mult_sched #(
    parameter int C_NCH          = 4,
    parameter int C_DIN_WIDTH    = 18,
    parameter int C_DOUT_WIDTH   = 32,
    parameter int C_MULT_LATENCY = 2,
    localparam int C_CHW         = (C_NCH > 2) ? $clog2(C_NCH) : 1
) (
    input  logic                          I_clk,
    input  logic                          I_rst_n,
    input  logic [C_NCH-1:0]              I_ch_en,
    input  logic [C_NCH-1:0]              I_req_v,
    output logic [C_NCH-1:0]              O_req_ready,
    input  logic [C_NCH*C_DIN_WIDTH-1:0]  I_req_d1i,
    input  logic [C_NCH*C_DIN_WIDTH-1:0]  I_req_d1q,
    input  logic [C_NCH*C_DIN_WIDTH-1:0]  I_req_d2i,
    input  logic [C_NCH*C_DIN_WIDTH-1:0]  I_req_d2q,
    output logic [C_DIN_WIDTH-1:0]        O_mult_d1i,
    output logic [C_DIN_WIDTH-1:0]        O_mult_d1q,
    output logic [C_DIN_WIDTH-1:0]        O_mult_d2i,
    output logic [C_DIN_WIDTH-1:0]        O_mult_d2q,
    output logic                          O_mult_v,
    input  logic [C_DOUT_WIDTH-1:0]       I_mult_i,
    input  logic [C_DOUT_WIDTH-1:0]       I_mult_q,
    input  logic                          I_mult_v,
    output logic [C_DOUT_WIDTH-1:0]       O_dout_i,
    output logic [C_DOUT_WIDTH-1:0]       O_dout_q,
    output logic [C_CHW-1:0]              O_dout_ch,
    output logic                          O_dout_v,
    output logic                          O_err
);

    function automatic int wrap_ch(input int v);
        return (v >= C_NCH) ? v - C_NCH : v;
    endfunction

    logic [C_CHW-1:0]        ptr_q, ptr_d;
    logic [C_NCH-1:0]        elig;
    logic [C_NCH-1:0]        grant;
    logic                    grant_any;
    logic [C_CHW-1:0]        grant_ch;
    logic                    xfer;

    logic [C_DIN_WIDTH-1:0]  mult_d1i_q, mult_d1i_d;
    logic [C_DIN_WIDTH-1:0]  mult_d1q_q, mult_d1q_d;
    logic [C_DIN_WIDTH-1:0]  mult_d2i_q, mult_d2i_d;
    logic [C_DIN_WIDTH-1:0]  mult_d2q_q, mult_d2q_d;
    logic                    mult_v_q, mult_v_d;
    logic [C_CHW-1:0]        issue_ch_q, issue_ch_d;

    logic                    tag_v_q  [C_MULT_LATENCY];
    logic                    tag_v_d  [C_MULT_LATENCY];
    logic [C_CHW-1:0]        tag_ch_q [C_MULT_LATENCY];
    logic [C_CHW-1:0]        tag_ch_d [C_MULT_LATENCY];

    logic [C_DOUT_WIDTH-1:0] dout_i_q, dout_i_d;
    logic [C_DOUT_WIDTH-1:0] dout_q_q, dout_q_d;
    logic [C_CHW-1:0]        dout_ch_q, dout_ch_d;
    logic                    dout_v_q, dout_v_d;
    logic                    err_q, err_d;

    // Scan order ptr, ptr+1, ... ; the outer loop is the scan position so the
    // first eligible channel in rotation order wins.
    always_comb begin
        elig      = I_req_v & I_ch_en;
        grant     = '0;
        grant_any = 1'b0;
        grant_ch  = '0;
        for (int i = 0; i < C_NCH; i++) begin
            for (int j = 0; j < C_NCH; j++) begin
                if (!grant_any && elig[j] && (j == wrap_ch(int'(ptr_q) + i))) begin
                    grant[j]  = 1'b1;
                    grant_any = 1'b1;
                    grant_ch  = C_CHW'(j);
                end
            end
        end
    end

    assign O_req_ready = I_rst_n ? grant : '0;
    assign xfer        = |(I_req_v & O_req_ready);

    always_comb begin
        ptr_d      = xfer ? C_CHW'(wrap_ch(int'(grant_ch) + 1)) : ptr_q;
        mult_v_d   = xfer;
        mult_d1i_d = mult_d1i_q;
        mult_d1q_d = mult_d1q_q;
        mult_d2i_d = mult_d2i_q;
        mult_d2q_d = mult_d2q_q;
        issue_ch_d = issue_ch_q;
        if (xfer) begin
            mult_d1i_d = I_req_d1i[int'(grant_ch)*C_DIN_WIDTH +: C_DIN_WIDTH];
            mult_d1q_d = I_req_d1q[int'(grant_ch)*C_DIN_WIDTH +: C_DIN_WIDTH];
            mult_d2i_d = I_req_d2i[int'(grant_ch)*C_DIN_WIDTH +: C_DIN_WIDTH];
            mult_d2q_d = I_req_d2q[int'(grant_ch)*C_DIN_WIDTH +: C_DIN_WIDTH];
            issue_ch_d = grant_ch;
        end
    end

    // The issue register {mult_v, issue_ch} is the head of the tag pipe; the
    // C_MULT_LATENCY stages behind it put the last tag in the same cycle the
    // multiplier presents I_mult_v for that operand pair.
    always_comb begin
        tag_v_d[0]  = mult_v_q;
        tag_ch_d[0] = issue_ch_q;
        for (int s = 1; s < C_MULT_LATENCY; s++) begin
            tag_v_d[s]  = tag_v_q[s-1];
            tag_ch_d[s] = tag_ch_q[s-1];
        end
    end

    always_comb begin
        dout_v_d  = I_mult_v;
        dout_i_d  = I_mult_v ? I_mult_i : dout_i_q;
        dout_q_d  = I_mult_v ? I_mult_q : dout_q_q;
        dout_ch_d = I_mult_v ? tag_ch_q[C_MULT_LATENCY-1] : dout_ch_q;
        err_d     = err_q | (I_mult_v != tag_v_q[C_MULT_LATENCY-1]);
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            ptr_q      <= '0;
            mult_d1i_q <= '0;
            mult_d1q_q <= '0;
            mult_d2i_q <= '0;
            mult_d2q_q <= '0;
            mult_v_q   <= 1'b0;
            issue_ch_q <= '0;
            for (int s = 0; s < C_MULT_LATENCY; s++) begin
                tag_v_q[s]  <= 1'b0;
                tag_ch_q[s] <= '0;
            end
            dout_i_q   <= '0;
            dout_q_q   <= '0;
            dout_ch_q  <= '0;
            dout_v_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            mult_d1i_q <= mult_d1i_d;
            mult_d1q_q <= mult_d1q_d;
            mult_d2i_q <= mult_d2i_d;
            mult_d2q_q <= mult_d2q_d;
            mult_v_q   <= mult_v_d;
            issue_ch_q <= issue_ch_d;
            for (int s = 0; s < C_MULT_LATENCY; s++) begin
                tag_v_q[s]  <= tag_v_d[s];
                tag_ch_q[s] <= tag_ch_d[s];
            end
            dout_i_q   <= dout_i_d;
            dout_q_q   <= dout_q_d;
            dout_ch_q  <= dout_ch_d;
            dout_v_q   <= dout_v_d;
            err_q      <= err_d;
        end
    end

    assign O_mult_d1i = mult_d1i_q;
    assign O_mult_d1q = mult_d1q_q;
    assign O_mult_d2i = mult_d2i_q;
    assign O_mult_d2q = mult_d2q_q;
    assign O_mult_v   = mult_v_q;
    assign O_dout_i   = dout_i_q;
    assign O_dout_q   = dout_q_q;
    assign O_dout_ch  = dout_ch_q;
    assign O_dout_v   = dout_v_q;
    assign O_err      = err_q;

endmodule
